// File: rtl/flit_link_pkg.sv
// rtl/flit_link_pkg.sv - shared types and defaults for the flit link arbiter
//
// Contents:
//   DEF_* constants   default parameter values for the arbiter slice
//   TAG_ID_W          id field width in the tag, large enough for 8 requesters
//   arb_state_t       IDLE (no packet open) / LOCKED (owner mid-packet)
//   flit_tag_t        {valid, id, tail} carried alongside each pipeline stage
//   wrap_inc          index + 1 modulo a requester count
package flit_link_pkg;

    localparam int DEF_FLIT_W     = 4;
    localparam int DEF_PIPE_DEPTH = 4;
    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_CREDITS    = 4;

    localparam int TAG_ID_W = 3;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
        logic                tail;
    } flit_tag_t;

    function automatic int wrap_inc(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/flit_rr_picker.sv
// rtl/flit_rr_picker.sv - combinational rotate-priority picker
//
// Ports:
//   req    in   NUM_REQ  request vector
//   ptr    in   ID_W     index searched first; search wraps upward
//   grant  out  NUM_REQ  one-hot grant, zero when no request
//   idx    out  ID_W     index of the granted request
//   any    out  1        at least one request present
module flit_rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    idx,
    output logic               any
);

    always_comb begin
        int j;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(ptr) + k;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            if (!any && req[j]) begin
                any      = 1'b1;
                idx      = ID_W'(j);
                grant[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/flit_link_arbiter.sv
// rtl/flit_link_arbiter.sv - packet round-robin arbiter with credit flow control
//
// Ports:
//   clk, rst       clock and async active-high reset shared with the flit pipeline
//   req_valid      per-requester flit present
//   req_flit       per-requester flit, requester i at [i*FLIT_W +: FLIT_W]
//   req_tail       per-requester last-flit-of-packet flag
//   req_ready      one-hot or zero acceptance
//   pipe_data_in   flit into the external delay pipeline, 0 on bubbles
//   credit_return  one pulse per freed downstream entry
//   out_valid      tag aligned with pipeline data_out: real flit
//   out_id         owner of the flit at data_out
//   out_tail       flit at data_out ends a packet
//   credit_cnt     credits currently available
//   credit_err     sticky credit overflow flag
module flit_link_arbiter
    import flit_link_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int FLIT_W     = DEF_FLIT_W,
    parameter int PIPE_DEPTH = DEF_PIPE_DEPTH,
    parameter int CREDITS    = DEF_CREDITS
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*FLIT_W-1:0]    req_flit,
    input  logic [NUM_REQ-1:0]           req_tail,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [FLIT_W-1:0]            pipe_data_in,
    input  logic                         credit_return,
    output logic                         out_valid,
    output logic [$clog2(NUM_REQ)-1:0]   out_id,
    output logic                         out_tail,
    output logic [$clog2(CREDITS+1)-1:0] credit_cnt,
    output logic                         credit_err
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(CREDITS + 1);

    arb_state_t        state;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   owner;
    flit_tag_t         tag_q [PIPE_DEPTH];

    logic [NUM_REQ-1:0] eligible;
    logic [ID_W-1:0]    search_ptr;
    logic [NUM_REQ-1:0] pick_grant;
    logic [ID_W-1:0]    pick_idx;
    logic               pick_any;
    logic               accept;
    logic               acc_tail;
    logic [ID_W-1:0]    next_ptr;

    // While a packet is open only the owner may compete, so other requesters
    // can never slip a flit into the middle of it.
    always_comb begin
        eligible   = req_valid;
        search_ptr = rr_ptr;
        if (state == LOCKED) begin
            eligible   = req_valid & (NUM_REQ'(1) << owner);
            search_ptr = owner;
        end
    end

    flit_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_picker (
        .req   (eligible),
        .ptr   (search_ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // Gated by rst so outputs read as reset values while reset is held,
    // even with requesters still asserting valid.
    assign accept   = pick_any && (credit_cnt != '0) && !rst;
    assign acc_tail = accept && req_tail[pick_idx];
    assign next_ptr = ID_W'(wrap_inc(int'(pick_idx), NUM_REQ));

    assign req_ready    = accept ? pick_grant : '0;
    assign pipe_data_in = accept ? req_flit[int'(pick_idx)*FLIT_W +: FLIT_W] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            rr_ptr <= '0;
            owner  <= '0;
        end else if (accept) begin
            if (state == IDLE) begin
                if (!acc_tail) begin
                    state <= LOCKED;
                    owner <= pick_idx;
                end else begin
                    rr_ptr <= next_ptr;
                end
            end else if (acc_tail) begin
                // In LOCKED the picker can only grant the owner, so next_ptr
                // is owner + 1.
                state  <= IDLE;
                rr_ptr <= next_ptr;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credit_cnt <= CNT_W'(CREDITS);
            credit_err <= 1'b0;
        end else begin
            case ({accept, credit_return})
                2'b10: credit_cnt <= credit_cnt - 1'b1;
                2'b01: begin
                    if (credit_cnt == CNT_W'(CREDITS)) begin
                        credit_err <= 1'b1;
                    end else begin
                        credit_cnt <= credit_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Free-running like the datapath: no stall, bubbles carry an all-zero tag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < PIPE_DEPTH; s++) begin
                tag_q[s] <= '0;
            end
        end else begin
            tag_q[0].valid <= accept;
            tag_q[0].id    <= accept ? TAG_ID_W'(pick_idx) : '0;
            tag_q[0].tail  <= acc_tail;
            for (int s = 1; s < PIPE_DEPTH; s++) begin
                tag_q[s] <= tag_q[s-1];
            end
        end
    end

    assign out_valid = tag_q[PIPE_DEPTH-1].valid;
    assign out_id    = tag_q[PIPE_DEPTH-1].id[ID_W-1:0];
    assign out_tail  = tag_q[PIPE_DEPTH-1].tail;

endmodule

// File: tb/tb_flit_link_arbiter.sv
// tb/tb_flit_link_arbiter.sv - directed self-checking bench for flit_link_arbiter
module tb_flit_link_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [15:0] req_flit;
    logic [3:0]  req_tail;
    logic [3:0]  req_ready;
    logic [3:0]  pipe_data_in;
    logic        credit_return;
    logic        out_valid;
    logic [1:0]  out_id;
    logic        out_tail;
    logic [2:0]  credit_cnt;
    logic        credit_err;

    int total;
    int bad;

    // Stand-in for the external 4-stage flit pipeline.
    logic [3:0] pd [4];
    logic [3:0] data_out;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < 4; s++) pd[s] <= '0;
        end else begin
            pd[0] <= pipe_data_in;
            for (int s = 1; s < 4; s++) pd[s] <= pd[s-1];
        end
    end
    assign data_out = pd[3];

    flit_link_arbiter dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_flit      (req_flit),
        .req_tail      (req_tail),
        .req_ready     (req_ready),
        .pipe_data_in  (pipe_data_in),
        .credit_return (credit_return),
        .out_valid     (out_valid),
        .out_id        (out_id),
        .out_tail      (out_tail),
        .credit_cnt    (credit_cnt),
        .credit_err    (credit_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [1:0] id,
                           input logic t, input logic [3:0] d);
        chk({tag, "_valid"}, 32'(out_valid), 32'(v));
        chk({tag, "_id"},    32'(out_id),    32'(id));
        chk({tag, "_tail"},  32'(out_tail),  32'(t));
        chk({tag, "_data"},  32'(data_out),  32'(d));
    endtask

    initial begin
        int exp_i;
        total         = 0;
        bad           = 0;
        rst           = 1'b1;
        req_valid     = '0;
        req_flit      = '0;
        req_tail      = '0;
        credit_return = 1'b0;

        // Reset values
        step();
        step();
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_pdin",  32'(pipe_data_in), 32'h0);
        chk_out("rst_out", 1'b0, 2'd0, 1'b0, 4'h0);
        chk("rst_cnt",   32'(credit_cnt), 32'd4);
        chk("rst_err",   32'(credit_err), 32'd0);
        rst = 1'b0;
        step();

        // Single-flit packet from req0 and its 4-edge latency
        req_valid = 4'b0001; req_flit[3:0] = 4'hA; req_tail = 4'b0001;
        #1;
        chk("t1_ready", 32'(req_ready), 32'h1);
        chk("t1_pdin",  32'(pipe_data_in), 32'hA);
        step();
        req_valid = '0; req_tail = '0;
        chk("t1_cnt", 32'(credit_cnt), 32'd3);
        credit_return = 1'b1;
        step();
        credit_return = 1'b0;
        chk("t1_cnt_back", 32'(credit_cnt), 32'd4);
        step();
        chk("t1_early_valid", 32'(out_valid), 32'd0);
        step();
        chk_out("t1_out", 1'b1, 2'd0, 1'b1, 4'hA);
        step();
        chk("t1_after_valid", 32'(out_valid), 32'd0);

        // req0 3-flit packet locks out req2; req2 follows without a bubble.
        // Credit returns here coincide with accepts at full credit.
        credit_return = 1'b1;
        req_valid = 4'b0001; req_flit[3:0] = 4'h1; req_tail = 4'b0000;
        #1;
        chk("t2_head_ready", 32'(req_ready), 32'h1);
        step();
        req_valid = 4'b0101; req_flit[3:0] = 4'h2; req_flit[11:8] = 4'h5; req_tail = 4'b0100;
        #1;
        chk("t2_body_ready", 32'(req_ready), 32'h1);
        chk("t2_body_pdin",  32'(pipe_data_in), 32'h2);
        step();
        req_flit[3:0] = 4'h3; req_tail = 4'b0101;
        #1;
        chk("t2_tail_ready", 32'(req_ready), 32'h1);
        step();
        req_valid = 4'b0100;
        #1;
        chk("t2_req2_ready", 32'(req_ready), 32'h4);
        chk("t2_req2_pdin",  32'(pipe_data_in), 32'h5);
        step();
        req_valid = '0; req_tail = '0; credit_return = 1'b0;
        chk_out("t2_o1", 1'b1, 2'd0, 1'b0, 4'h1);
        chk("t2_cnt", 32'(credit_cnt), 32'd4);
        chk("t2_err", 32'(credit_err), 32'd0);
        step();
        chk_out("t2_o2", 1'b1, 2'd0, 1'b0, 4'h2);
        step();
        chk_out("t2_o3", 1'b1, 2'd0, 1'b1, 4'h3);
        step();
        chk_out("t2_o4", 1'b1, 2'd2, 1'b1, 4'h5);

        // All requesters valid with single flits; rr_ptr is 3 after req2
        req_valid = 4'b1111; req_tail = 4'b1111; credit_return = 1'b1;
        for (int i = 0; i < 4; i++) req_flit[i*4 +: 4] = 4'(8 + i);
        for (int k = 0; k < 5; k++) begin
            exp_i = (3 + k) % 4;
            #1;
            chk("t3_ready", 32'(req_ready), 32'(1 << exp_i));
            chk("t3_pdin",  32'(pipe_data_in), 32'(8 + exp_i));
            step();
            chk("t3_cnt", 32'(credit_cnt), 32'd4);
        end
        chk("t3_err", 32'(credit_err), 32'd0);
        req_valid = '0; req_tail = '0; credit_return = 1'b0;

        // Credit exhaustion: 6 offered, 4 accepted
        req_valid = 4'b0001; req_tail = 4'b0001;
        for (int i = 0; i < 6; i++) begin
            req_flit[3:0] = 4'(i);
            #1;
            chk("t4_ready", 32'(req_ready), (i < 4) ? 32'h1 : 32'h0);
            chk("t4_pdin",  32'(pipe_data_in), (i < 4) ? 32'(i) : 32'h0);
            step();
        end
        chk("t4_cnt_zero", 32'(credit_cnt), 32'd0);
        credit_return = 1'b1;
        #1;
        chk("t4_ret_cycle_ready", 32'(req_ready), 32'h0);
        step();
        credit_return = 1'b0;
        chk("t4_cnt_one", 32'(credit_cnt), 32'd1);
        chk("t4_regrant_ready", 32'(req_ready), 32'h1);
        step();
        chk("t4_cnt_again", 32'(credit_cnt), 32'd0);
        chk("t4_stop_ready", 32'(req_ready), 32'h0);
        req_valid = '0; req_tail = '0;
        credit_return = 1'b1;
        for (int i = 0; i < 4; i++) step();
        credit_return = 1'b0;
        chk("t4_cnt_full", 32'(credit_cnt), 32'd4);

        // Mid-packet reset: req1 locked after two flits
        req_valid = 4'b0010; req_flit[7:4] = 4'h6; req_tail = 4'b0000;
        step();
        req_flit[7:4] = 4'h7;
        step();
        req_valid = 4'b1010; req_flit[7:4] = 4'h8; req_flit[15:12] = 4'h9;
        #1;
        chk("t5_locked_ready", 32'(req_ready), 32'h2);
        rst = 1'b1;
        #1;
        chk("t5_rst_ready", 32'(req_ready), 32'h0);
        chk("t5_rst_pdin",  32'(pipe_data_in), 32'h0);
        chk_out("t5_rst_out", 1'b0, 2'd0, 1'b0, 4'h0);
        chk("t5_rst_cnt",   32'(credit_cnt), 32'd4);
        chk("t5_rst_err",   32'(credit_err), 32'd0);
        step();
        rst = 1'b0;
        req_valid = 4'b1000;
        #1;
        chk("t5_req3_ready", 32'(req_ready), 32'h8);
        chk("t5_req3_pdin",  32'(pipe_data_in), 32'h9);
        step();
        req_valid = '0;
        chk("t5_cnt", 32'(credit_cnt), 32'd3);

        // Credit overflow without an accept sets a sticky error
        credit_return = 1'b1;
        step();
        chk("t6_cnt_full", 32'(credit_cnt), 32'd4);
        chk("t6_err_clear", 32'(credit_err), 32'd0);
        step();
        credit_return = 1'b0;
        chk("t6_cnt_hold", 32'(credit_cnt), 32'd4);
        chk("t6_err_set", 32'(credit_err), 32'd1);
        step();
        chk("t6_err_sticky", 32'(credit_err), 32'd1);
        rst = 1'b1;
        #1;
        chk("t6_err_rst", 32'(credit_err), 32'd0);
        step();
        rst = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
